dcache_writeback: RTL and testbench
===================================

DCACHE_WRITEBACK -- requirements
Module: dcache_writeback

Interface
REQ-001 Parameters SHALL be: LINE_WORDS, default Dcacheline_len, words per cache line; WAY_NUM, default Dcache_way_num, ways per set; INDEX_BITS, default Dcache_index_bits, set index width.
REQ-002 Ports SHALL be: clk  in  1  single clock; reset is synchronous and active-high.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 wb_valid  in  1  writeback request; wb_ready  out  1  engine accepts a request.
REQ-005 wb_index  in  INDEX_BITS  victim set; wb_way  in  $clog2(WAY_NUM)  victim way; wb_addr  in  32  line base byte address.
REQ-006 bram_raddr  out  INDEX_BITS  data-array read address; bram_rdata  in  32*LINE_WORDS*WAY_NUM  data-array read data, valid one cycle after bram_raddr.
REQ-007 aw_valid  out  1; aw_ready  in  1; aw_addr  out  32; aw_len  out  8  burst length minus 1.
REQ-008 w_valid  out  1; w_ready  in  1; w_data  out  32; w_strb  out  4; w_last  out  1.
REQ-009 b_valid  in  1; b_ready  out  1; wb_done  out  1  one-cycle completion pulse.

Function
REQ-010 States SHALL be IDLE, RD, CAP, AW, W, B.
REQ-011 IDLE: wb_ready=1. On wb_valid, latch index, way and addr, drive bram_raddr=wb_index in the same cycle, and go to RD.
REQ-012 RD: wait one cycle for the one-cycle BRAM read latency; then go to CAP.
REQ-013 CAP: latch the LINE_WORDS words of way wb_way from bram_rdata into the line buffer, with way w occupying bits [32*LINE_WORDS*(w+1)-1 : 32*LINE_WORDS*w] and word 0 in the LSBs; then go to AW.
REQ-014 AW: aw_valid=1, aw_addr=latched addr with the low $clog2(4*LINE_WORDS) bits cleared, aw_len=LINE_WORDS-1. On aw_ready, go to W.
REQ-015 W: w_valid=1, w_data=buffer[word_cnt], w_strb=4'hF, w_last=(word_cnt==LINE_WORDS-1). On a w_ready handshake, word_cnt increments. A handshake with w_last set goes to B.
REQ-016 word_cnt SHALL be $clog2(LINE_WORDS) bits wide, SHALL start at 0 on entry to W, and SHALL never wrap within a burst.
REQ-017 B: b_ready=1. On b_valid, pulse wb_done for one cycle and go to IDLE; the next request SHALL be accepted no earlier than the following cycle.
REQ-018 valid outputs SHALL hold stable with unchanged payload until their handshake completes; a stalled ready SHALL not corrupt the buffer.
REQ-019 wb_valid outside IDLE SHALL be ignored (wb_ready=0).
REQ-020 Latency from request to the first aw_valid SHALL be 3 cycles with no stalls.

Reset
REQ-021 While reset is high: state=IDLE; wb_ready=1 after reset; aw_valid, w_valid, w_last, b_ready and wb_done=0; word_cnt=0; the buffer is not reset.
REQ-022 Reset mid-burst SHALL abandon the transfer immediately with no further handshakes.

Configuration
REQ-023 Macro DCACHE_WB_EARLY_DONE_EN: when defined, wb_done SHALL pulse on the w_last handshake, and state B SHALL still absorb b_valid before returning to IDLE. When undefined, the behaviour is as in REQ-017.

Structure
REQ-024 The state enum dcache_wb_state_t and DCACHE_WB_BURST_LEN SHALL reside in the shared cache package with the Dcache_* constants.
REQ-025 The line buffer plus word mux SHALL be a single sub-module, dcache_wb_linebuf; the FSM SHALL stay in dcache_writeback.

Verification
REQ-026 LINE_WORDS=8, WAY_NUM=2, request index=5, way=1, addr=0x8000_1234, all ready signals=1 -> bram_raddr=5, aw_addr=0x8000_1220, aw_len=7, 8 beats of way-1 words, w_last on beat 7, wb_done one cycle after b_valid.
REQ-027 w_ready toggling 1,0,0,1 per beat -> w_data held stable across the stalls; beat order is preserved.
REQ-028 aw_ready held low for 5 cycles -> aw_valid and aw_addr are held stable, and w_valid=0 throughout.
REQ-029 Second wb_valid asserted during W -> it is ignored; it is accepted only after wb_done.
REQ-030 Reset asserted at beat 3 -> next cycle: all valid outputs=0, state=IDLE; a fresh request completes normally.
REQ-031 With DCACHE_WB_EARLY_DONE_EN and b_valid delayed 4 cycles -> wb_done on the w_last handshake; wb_ready returns only after b_valid.

Source files
------------

// File: rtl/dcache_writeback_pkg.sv
// Shared data-cache package: geometry constants, writeback burst length and
// the writeback engine state encoding.
package dcache_writeback_pkg;

  localparam int unsigned Dcacheline_len    = 8;
  localparam int unsigned Dcache_way_num    = 2;
  localparam int unsigned Dcache_index_bits = 6;

  localparam logic [7:0] DCACHE_WB_BURST_LEN = 8'(Dcacheline_len - 1);

  typedef enum logic [2:0] {
    WB_IDLE,
    WB_RD,
    WB_CAP,
    WB_AW,
    WB_W,
    WB_B
  } dcache_wb_state_t;

endpackage

// File: rtl/dcache_wb_linebuf.sv
// Victim line buffer: captures one way of a data-array read and presents
// the selected word to the write channel.
module dcache_wb_linebuf #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned WAY_NUM    = 2,
  localparam int unsigned WAY_W     = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
  localparam int unsigned CNT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic                             clk,
  input  logic                             cap_en,
  input  logic [WAY_W-1:0]                 cap_way,
  input  logic [32*LINE_WORDS*WAY_NUM-1:0] rdata,
  input  logic [CNT_W-1:0]                 word_sel,
  output logic [31:0]                      word
);

  logic [31:0] line_q [LINE_WORDS];

  // Contents only change on capture, so stalled beats see a stable line.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      for (int unsigned i = 0; i < LINE_WORDS; i++) begin
        line_q[i] <= rdata[(LINE_WORDS * 32'(cap_way) + i) * 32 +: 32];
      end
    end
  end

  assign word = line_q[word_sel];

endmodule

// File: rtl/dcache_writeback.sv
// Data-cache victim writeback engine: reads a line from the data array and
// writes it out as one AXI-style burst. Optional DCACHE_WB_EARLY_DONE_EN.
module dcache_writeback
  import dcache_writeback_pkg::*;
#(
  parameter int unsigned LINE_WORDS = Dcacheline_len,
  parameter int unsigned WAY_NUM    = Dcache_way_num,
  parameter int unsigned INDEX_BITS = Dcache_index_bits,
  localparam int unsigned WAY_W     = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wb_valid,
  output logic                             wb_ready,
  input  logic [INDEX_BITS-1:0]            wb_index,
  input  logic [WAY_W-1:0]                 wb_way,
  input  logic [31:0]                      wb_addr,
  output logic [INDEX_BITS-1:0]            bram_raddr,
  input  logic [32*LINE_WORDS*WAY_NUM-1:0] bram_rdata,
  output logic                             aw_valid,
  input  logic                             aw_ready,
  output logic [31:0]                      aw_addr,
  output logic [7:0]                       aw_len,
  output logic                             w_valid,
  input  logic                             w_ready,
  output logic [31:0]                      w_data,
  output logic [3:0]                       w_strb,
  output logic                             w_last,
  input  logic                             b_valid,
  output logic                             b_ready,
  output logic                             wb_done
);

  localparam int unsigned CNT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned OFF_W     = $clog2(4 * LINE_WORDS);
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

  dcache_wb_state_t state, state_nxt;

  logic [INDEX_BITS-1:0] idx_q;
  logic [WAY_W-1:0]      way_q;
  logic [31:0]           addr_q;
  logic [CNT_W-1:0]      word_cnt;
  logic                  cap_en;

  always_ff @(posedge clk) begin
    if (reset) state <= WB_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt <= '0;
    end else begin
      if (state == WB_IDLE && wb_valid) begin
        idx_q  <= wb_index;
        way_q  <= wb_way;
        addr_q <= wb_addr;
      end
      // Counter parks at the last word; leaving W clears it for the next burst.
      if (state != WB_W)
        word_cnt <= '0;
      else if (w_ready && word_cnt != LAST_WORD)
        word_cnt <= word_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    wb_ready   = 1'b0;
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    w_last     = 1'b0;
    b_ready    = 1'b0;
    cap_en     = 1'b0;
    bram_raddr = idx_q;
    case (state)
      WB_IDLE: begin
        wb_ready   = 1'b1;
        bram_raddr = wb_index;
        if (wb_valid) state_nxt = WB_RD;
      end
      WB_RD:  state_nxt = WB_CAP;
      WB_CAP: begin
        cap_en    = 1'b1;
        state_nxt = WB_AW;
      end
      WB_AW: begin
        aw_valid = 1'b1;
        if (aw_ready) state_nxt = WB_W;
      end
      WB_W: begin
        w_valid = 1'b1;
        w_last  = (word_cnt == LAST_WORD);
        if (w_ready && w_last) state_nxt = WB_B;
      end
      WB_B: begin
        b_ready = 1'b1;
        if (b_valid) state_nxt = WB_IDLE;
      end
      default: state_nxt = WB_IDLE;
    endcase
    // Reset kills every handshake in the same cycle, not just after the edge.
    if (reset) begin
      wb_ready  = 1'b0;
      aw_valid  = 1'b0;
      w_valid   = 1'b0;
      w_last    = 1'b0;
      b_ready   = 1'b0;
      cap_en    = 1'b0;
      state_nxt = WB_IDLE;
    end
  end

  assign aw_addr = addr_q & ADDR_MASK;
  assign aw_len  = 8'(LINE_WORDS - 1);
  assign w_strb  = 4'hF;

`ifdef DCACHE_WB_EARLY_DONE_EN
  assign wb_done = w_valid && w_ready && w_last;
`else
  logic done_q;

  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= (state == WB_B) && b_valid;
  end

  assign wb_done = done_q && !reset;
`endif

  dcache_wb_linebuf #(
    .LINE_WORDS (LINE_WORDS),
    .WAY_NUM    (WAY_NUM)
  ) u_linebuf (
    .clk      (clk),
    .cap_en   (cap_en),
    .cap_way  (way_q),
    .rdata    (bram_rdata),
    .word_sel (word_cnt),
    .word     (w_data)
  );

endmodule

// File: tb/tb_dcache_writeback.sv
// Directed bench for dcache_writeback (LINE_WORDS=8, WAY_NUM=2).
module tb_dcache_writeback;
  import dcache_writeback_pkg::*;

  localparam int unsigned LW = 8;
  localparam int unsigned WN = 2;
  localparam int unsigned IB = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb_valid;
  logic              wb_ready;
  logic [IB-1:0]     wb_index;
  logic              wb_way;
  logic [31:0]       wb_addr;
  logic [IB-1:0]     bram_raddr;
  logic [32*LW*WN-1:0] bram_rdata;
  logic              aw_valid, aw_ready;
  logic [31:0]       aw_addr;
  logic [7:0]        aw_len;
  logic              w_valid, w_ready;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic              w_last;
  logic              b_valid, b_ready;
  logic              wb_done;

  int errors = 0;
  int checks = 0;

  dcache_writeback #(
    .LINE_WORDS (LW),
    .WAY_NUM    (WN),
    .INDEX_BITS (IB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_index   (wb_index),
    .wb_way     (wb_way),
    .wb_addr    (wb_addr),
    .bram_raddr (bram_raddr),
    .bram_rdata (bram_rdata),
    .aw_valid   (aw_valid),
    .aw_ready   (aw_ready),
    .aw_addr    (aw_addr),
    .aw_len     (aw_len),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .w_strb     (w_strb),
    .w_last     (w_last),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .wb_done    (wb_done)
  );

  always #5 clk = ~clk;

  // Word contents encode set, way and word number, e.g. set 5 way 1 word 3 = 0x0501A503.
  function automatic logic [31:0] word_of(input int unsigned idx, input int unsigned way,
                                          input int unsigned wd);
    return {8'(idx), 8'(way), 8'hA5, 8'(wd)};
  endfunction

  always @(posedge clk) begin
    for (int unsigned w = 0; w < WN; w++)
      for (int unsigned i = 0; i < LW; i++)
        bram_rdata[(w*LW + i)*32 +: 32] <= word_of(bram_raddr, w, i);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one request and checks the fixed 3-cycle latency to aw_valid; returns in the AW cycle.
  task automatic start_req(input int unsigned idx, input int unsigned way, input logic [31:0] addr);
    wb_valid = 1'b1; wb_index = IB'(idx); wb_way = 1'(way); wb_addr = addr;
    #1;
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL req_ready: got %b want 1", wb_ready); end
    checks++; if (bram_raddr !== IB'(idx)) begin errors++; $display("FAIL bram_raddr: got %0d want %0d", bram_raddr, idx); end
    tick;
    wb_valid = 1'b0;
    for (int n = 1; n < 3; n++) begin
      #1;
      checks++; if (aw_valid !== 1'b0) begin errors++; $display("FAIL aw_early cycle %0d: got %b want 0", n, aw_valid); end
      tick;
    end
    #1;
    checks++; if (aw_valid !== 1'b1) begin errors++; $display("FAIL aw_latency: got %b want 1", aw_valid); end
  endtask

  // Eight beats with w_ready held high; returns in the B cycle.
  task automatic beats(input int unsigned idx, input int unsigned way);
    for (int unsigned i = 0; i < LW; i++) begin
      w_ready = 1'b1;
      #1;
      checks++;
      if (w_valid !== 1'b1 || w_data !== word_of(idx, way, i) || w_last !== (i == LW-1) || w_strb !== 4'hF) begin
        errors++;
        $display("FAIL beat %0d: got v=%b d=%h last=%b strb=%h want v=1 d=%h last=%b strb=f",
                 i, w_valid, w_data, w_last, w_strb, word_of(idx, way, i), (i == LW-1));
      end
`ifdef DCACHE_WB_EARLY_DONE_EN
      checks++; if (wb_done !== (i == LW-1)) begin errors++; $display("FAIL early_done beat %0d: got %b", i, wb_done); end
`endif
      tick;
    end
  endtask

  // Immediate b_valid; returns in the IDLE cycle after the response.
  task automatic finish_b;
    #1;
    checks++; if (b_ready !== 1'b1 || w_valid !== 1'b0) begin errors++; $display("FAIL b_state: got b_ready=%b w_valid=%b want 1 0", b_ready, w_valid); end
    checks++; if (wb_done !== 1'b0) begin errors++; $display("FAIL done_before_b: got %b want 0", wb_done); end
    b_valid = 1'b1;
    tick;
    b_valid = 1'b0;
    #1;
`ifdef DCACHE_WB_EARLY_DONE_EN
    checks++; if (wb_done !== 1'b0) begin errors++; $display("FAIL done_after_b: got %b want 0", wb_done); end
`else
    checks++; if (wb_done !== 1'b1) begin errors++; $display("FAIL done_after_b: got %b want 1", wb_done); end
`endif
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL ready_after_b: got %b want 1", wb_ready); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wb_valid = 1'b0; wb_index = '0; wb_way = 1'b0; wb_addr = '0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
    tick; tick;
    checks++;
    if ({aw_valid, w_valid, w_last, b_ready, wb_done} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 00000", {aw_valid, w_valid, w_last, b_ready, wb_done});
    end
    reset = 1'b0;
    #1;
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", wb_ready); end
  endtask

  task automatic test_basic;
    aw_ready = 1'b1; w_ready = 1'b1;
    start_req(5, 1, 32'h8000_1234);
    checks++; if (aw_addr !== 32'h8000_1220) begin errors++; $display("FAIL aw_addr: got %h want 80001220", aw_addr); end
    checks++; if (aw_len !== 8'd7 || aw_len !== DCACHE_WB_BURST_LEN) begin errors++; $display("FAIL aw_len: got %0d want 7", aw_len); end
    checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL w_during_aw: got %b want 0", w_valid); end
    tick;
    beats(5, 1);
    finish_b;
    tick;
    checks++; if (wb_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", wb_done); end
  endtask

  task automatic test_w_stall;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int unsigned beat = 0;
    int cyc = 0;
    aw_ready = 1'b1;
    start_req(2, 0, 32'h0000_0047);
    checks++; if (aw_addr !== 32'h0000_0040) begin errors++; $display("FAIL stall_aw_addr: got %h want 00000040", aw_addr); end
    tick;
    while (beat < LW && cyc < 64) begin
      w_ready = pat[cyc % 4];
      #1;
      checks++;
      if (w_valid !== 1'b1 || w_data !== word_of(2, 0, beat) || w_last !== (beat == LW-1)) begin
        errors++;
        $display("FAIL stall_beat %0d cyc %0d: got v=%b d=%h last=%b want v=1 d=%h", beat, cyc, w_valid, w_data, w_last, word_of(2, 0, beat));
      end
      if (w_ready) beat++;
      tick;
      cyc++;
    end
    checks++; if (beat != LW) begin errors++; $display("FAIL stall_beats_done: got %0d want %0d", beat, LW); end
    w_ready = 1'b1;
    finish_b;
    tick;
  endtask

  task automatic test_aw_stall;
    aw_ready = 1'b0; w_ready = 1'b1;
    start_req(9, 1, 32'h1234_5678);
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++;
      if (aw_valid !== 1'b1 || aw_addr !== 32'h1234_5660 || w_valid !== 1'b0) begin
        errors++; $display("FAIL aw_hold %0d: got v=%b a=%h w=%b want 1 12345660 0", n, aw_valid, aw_addr, w_valid);
      end
      tick;
    end
    aw_ready = 1'b1;
    #1;
    tick;
    beats(9, 1);
    finish_b;
    tick;
  endtask

  task automatic test_ignore;
    aw_ready = 1'b1; w_ready = 1'b1;
    start_req(5, 1, 32'h8000_1234);
    tick;
    for (int unsigned i = 0; i < LW; i++) begin
      if (i == 2) begin
        wb_valid = 1'b1; wb_index = 6'd7; wb_way = 1'b0; wb_addr = 32'h0000_1000;
      end
      #1;
      checks++;
      if (w_data !== word_of(5, 1, i) || (i >= 2 && wb_ready !== 1'b0)) begin
        errors++; $display("FAIL ignore_beat %0d: got d=%h rdy=%b want d=%h rdy=0", i, w_data, wb_ready, word_of(5, 1, i));
      end
      tick;
    end
    #1;
    checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL ignore_in_b: got %b want 0", wb_ready); end
    finish_b;
    start_req(7, 0, 32'h0000_1000);
    checks++; if (aw_addr !== 32'h0000_1000) begin errors++; $display("FAIL second_aw_addr: got %h want 00001000", aw_addr); end
    tick;
    beats(7, 0);
    finish_b;
    tick;
  endtask

  task automatic test_reset_mid;
    aw_ready = 1'b1; w_ready = 1'b1;
    start_req(3, 0, 32'h0000_0040);
    tick;
    for (int n = 0; n < 3; n++) tick;
    reset = 1'b1;
    #1;
    checks++;
    if ({aw_valid, w_valid, w_last, b_ready, wb_done} !== 5'b0) begin
      errors++; $display("FAIL mid_reset_now: got %b want 00000", {aw_valid, w_valid, w_last, b_ready, wb_done});
    end
    tick;
    reset = 1'b0;
    #1;
    checks++;
    if (wb_ready !== 1'b1 || {aw_valid, w_valid, b_ready} !== 3'b0) begin
      errors++; $display("FAIL mid_reset_idle: got rdy=%b v=%b want 1 000", wb_ready, {aw_valid, w_valid, b_ready});
    end
    start_req(4, 1, 32'h2000_0010);
    checks++; if (aw_addr !== 32'h2000_0000) begin errors++; $display("FAIL fresh_aw_addr: got %h want 20000000", aw_addr); end
    tick;
    beats(4, 1);
    finish_b;
    tick;
  endtask

  task automatic test_b_delay;
    aw_ready = 1'b1; w_ready = 1'b1;
    start_req(6, 0, 32'h0000_0100);
    tick;
    beats(6, 0);
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++;
      if (b_ready !== 1'b1 || wb_ready !== 1'b0 || wb_done !== 1'b0) begin
        errors++; $display("FAIL b_wait %0d: got b_ready=%b rdy=%b done=%b want 1 0 0", n, b_ready, wb_ready, wb_done);
      end
      tick;
    end
    finish_b;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_w_stall;
    test_aw_stall;
    test_ignore;
    test_reset_mid;
    test_b_delay;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
